// File: rtl/ram_bus_pkg.sv
// Shared types and opcode constants for the RAM bus controller.
// Also holds the rule for which instructions take two bus cycles.
package ram_bus_pkg;

    typedef enum logic [2:0] {
        PH_A1, PH_A2, PH_A3, PH_M1, PH_M2, PH_X1, PH_X2, PH_X3
    } phase_e;

    localparam logic [3:0] OPR_JCN     = 4'h1;
    localparam logic [3:0] OPR_SRC_FIM = 4'h2;
    localparam logic [3:0] OPR_FIN_JIN = 4'h3;
    localparam logic [3:0] OPR_JUN     = 4'h4;
    localparam logic [3:0] OPR_JMS     = 4'h5;
    localparam logic [3:0] OPR_ISZ     = 4'h7;
    localparam logic [3:0] OPR_IO      = 4'hE;

    localparam logic [3:0] OPA_WRM = 4'h0;
    localparam logic [3:0] OPA_WMP = 4'h1;
    localparam logic [3:0] OPA_WR0 = 4'h4;
    localparam logic [3:0] OPA_SBM = 4'h8;
    localparam logic [3:0] OPA_RDM = 4'h9;
    localparam logic [3:0] OPA_ADM = 4'hB;
    localparam logic [3:0] OPA_RD0 = 4'hC;

    // The OPA bit 0 distinguishes FIM/SRC and FIN/JIN; only the even forms carry a second word.
    function automatic logic is_two_cycle(input logic [3:0] opr, input logic [3:0] opa);
        case (opr)
            OPR_JCN, OPR_JUN, OPR_JMS, OPR_ISZ: return 1'b1;
            OPR_SRC_FIM, OPR_FIN_JIN:           return !opa[0];
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cycle_phase_counter.sv
// Eight-phase instruction-cycle counter aligned by the CPU sync pulse.
// resync flags a sync that arrives anywhere other than the expected phase once locked.
module cycle_phase_counter #(
    parameter int SYNC_PHASE = 7
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                sync,
    output ram_bus_pkg::phase_e phase,
    output logic                locked,
    output logic                resync
);
    import ram_bus_pkg::*;

    localparam logic [2:0] SYNC_PH = 3'(SYNC_PHASE);

    assign resync = sync && locked && (phase != SYNC_PH);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            phase  <= PH_A1;
            locked <= 1'b0;
        end else if (sync) begin
            phase  <= PH_A1;
            locked <= 1'b1;
        end else begin
            phase  <= phase_e'(phase + 3'd1);
        end
    end

endmodule

// File: rtl/ram_bus_controller.sv
// Passive bus sequencer: follows the CPU instruction cycle, latches SRC addresses
// and turns RAM-class I/O instructions into single-cycle X2 strobes.
module ram_bus_controller #(
    parameter int NUM_BANKS  = 4,
    parameter int SYNC_PHASE = 7
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         sync,
    input  logic [3:0]                   data_in,
    input  logic [NUM_BANKS-1:0]         cm_ram,
    output logic [2:0]                   phase,
    output logic                         locked,
    output logic                         src_valid,
    output logic [$clog2(NUM_BANKS)-1:0] sel_bank,
    output logic [1:0]                   sel_chip,
    output logic [1:0]                   sel_reg,
    output logic [3:0]                   sel_char,
    output logic                         mem_we,
    output logic                         status_we,
    output logic                         port_we,
    output logic                         mem_re,
    output logic                         status_re,
    output logic [1:0]                   status_idx,
    output logic [3:0]                   wr_data,
    output logic                         bus_drive
);
    import ram_bus_pkg::*;

    localparam int BANK_W = $clog2(NUM_BANKS);

    phase_e               ph;
    logic                 resync;
    logic [3:0]           opr;
    logic [3:0]           opa;
    logic [NUM_BANKS-1:0] cm_m2;
    logic                 second_word;
    logic                 src_pending;
    logic [BANK_W-1:0]    bank_idx;
    logic                 io_go;

    cycle_phase_counter #(.SYNC_PHASE(SYNC_PHASE)) u_phase (
        .clock  (clock),
        .reset  (reset),
        .sync   (sync),
        .phase  (ph),
        .locked (locked),
        .resync (resync)
    );

    assign phase   = ph;
    assign wr_data = mem_we ? data_in : 4'h0;

    // NOTE: give combinational outputs a default before the loop so no latch is inferred.
    always_comb begin
        bank_idx = '0;
        for (int i = NUM_BANKS - 1; i >= 0; i--) begin
            if (cm_ram[i]) bank_idx = BANK_W'(i);
        end
    end

    // Strobes are computed in X1 so they are registered exactly for the X2 cycle.
    assign io_go = locked && !resync && !second_word && (ph == PH_X1) &&
                   (opr == OPR_IO) && (|cm_m2) && src_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            opr <= '0; opa <= '0; cm_m2 <= '0;
            second_word <= 1'b0; src_pending <= 1'b0; src_valid <= 1'b0;
            sel_bank <= '0; sel_chip <= '0; sel_reg <= '0; sel_char <= '0;
            mem_we <= 1'b0; status_we <= 1'b0; port_we <= 1'b0;
            mem_re <= 1'b0; status_re <= 1'b0; bus_drive <= 1'b0;
            status_idx <= '0;
        end else begin
            mem_we <= 1'b0; status_we <= 1'b0; port_we <= 1'b0;
            mem_re <= 1'b0; status_re <= 1'b0; bus_drive <= 1'b0;
            status_idx <= '0;
            if (io_go) begin
                if (opa == OPA_WRM) begin
                    mem_we <= 1'b1;
                end else if (opa == OPA_WMP) begin
                    port_we <= 1'b1;
                end else if (opa[3:2] == OPA_WR0[3:2]) begin
                    status_we  <= 1'b1;
                    status_idx <= opa[1:0];
                end else if (opa == OPA_SBM || opa == OPA_RDM || opa == OPA_ADM) begin
                    mem_re    <= 1'b1;
                    bus_drive <= 1'b1;
                end else if (opa[3:2] == OPA_RD0[3:2]) begin
                    status_re  <= 1'b1;
                    bus_drive  <= 1'b1;
                    status_idx <= opa[1:0];
                end
            end

            if (locked && !resync) begin
                case (ph)
                    PH_M1: opr <= data_in;
                    PH_M2: begin
                        opa   <= data_in;
                        cm_m2 <= cm_ram;
                    end
                    PH_X2: begin
                        if (!second_word && opr == OPR_SRC_FIM && opa[0] && (|cm_ram)) begin
                            sel_bank    <= bank_idx;
                            sel_chip    <= data_in[3:2];
                            sel_reg     <= data_in[1:0];
                            src_pending <= 1'b1;
                        end
                    end
                    PH_X3: begin
                        if (src_pending) begin
                            sel_char  <= data_in;
                            src_valid <= 1'b1;
                        end
                        src_pending <= 1'b0;
                        second_word <= !second_word && is_two_cycle(opr, opa);
                    end
                    default: ;
                endcase
            end

            if (resync) begin
                src_pending <= 1'b0;
                second_word <= 1'b0;
            end
        end
    end

endmodule

// File: doc/ram_bus_controller.md
Name: ram_bus_controller

Overview:
- Passive sequencer between the 4-bit CPU bus and the RAM chips.
- Tracks the 8-phase instruction cycle (A1 A2 A3 M1 M2 X1 X2 X3) from sync.
- Latches the SRC address and decodes RAM-class I/O instructions (OPR=0xE).
- Issues single-cycle read/write strobes so RAM chips hold no bus-decoding logic of their own.

Parameters:
- NUM_BANKS, 4, number of CM-RAM lines (one RAM bank per line); sel_bank width is clog2(NUM_BANKS).
- SYNC_PHASE, 7, phase index during which sync is legally asserted (X3).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sync  in  1  high during X3; the following cycle is A1
- data_in  in  4  CPU bus value, sampled every clock
- cm_ram  in  NUM_BANKS  CM-RAM lines, one-hot per bank, meaningful at M2 and X2
- phase  out  3  current phase, 0=A1 .. 7=X3
- locked  out  1  phase tracking valid (first sync seen)
- src_valid  out  1  an SRC address has been latched
- sel_bank  out  clog2(NUM_BANKS)  bank of latched SRC
- sel_chip  out  2  chip within bank
- sel_reg  out  2  register within chip
- sel_char  out  4  character index
- mem_we  out  1  write main character (WRM)
- status_we  out  1  write status character (WR0-3)
- port_we  out  1  write output port (WMP)
- mem_re  out  1  read main character (RDM/SBM/ADM)
- status_re  out  1  read status character (RD0-3)
- status_idx  out  2  status index for WRn/RDn
- wr_data  out  4  data to write
- bus_drive  out  1  RAM must drive the bus this cycle

Behaviour:
- Reset: phase=0, locked=0, src_valid=0, all sel_* = 0, all strobes/bus_drive/wr_data/status_idx = 0, second_word=0.
- Phase counter:
  - sync high → next phase = A1 and locked=1.
  - Otherwise the counter increments mod 8.
  - sync in any phase ≠ SYNC_PHASE is a resync: counter restarts at A1 and any in-flight decoded command is dropped (no strobe that cycle).
- While locked=0, no latching occurs and no strobes are issued.
- M1: capture OPR = data_in.
- M2: capture OPA = data_in and cm_ram.
- Two-word/two-cycle tracking: second_word is set at X3 when the captured instruction is JCN (OPR 1), FIM (OPR 2, OPA[0]=0), FIN (OPR 3, OPA[0]=0), JUN (4), JMS (5) or ISZ (7). The next cycle's M1/M2 are then not decoded, and second_word clears at the end of that cycle.
- Bank select: the lowest-index set bit of cm_ram wins. cm_ram=0 means no RAM action.
- SRC (OPR 2, OPA[0]=1, cm_ram≠0 at X2):
  - At X2: latch sel_bank, sel_chip=data_in[3:2], sel_reg=data_in[1:0].
  - At X3: latch sel_char=data_in and set src_valid.
  - A later SRC overwrites all fields; src_valid stays 1.
- RAM I/O (OPR 0xE, cm_ram≠0 at M2, src_valid=1): exactly one of the following strobes is high during the X2 cycle only (registered, asserted on the edge entering X2, deasserted on the edge leaving it):
  - OPA 0 → mem_we, wr_data=data_in (combinational pass-through during X2).
  - OPA 1 → port_we.
  - OPA 4-7 → status_we, status_idx=OPA[1:0].
  - OPA 8, 9, B → mem_re and bus_drive.
  - OPA C-F → status_re and bus_drive, status_idx=OPA[1:0].
  - OPA 2, 3, A (ROM-side ops) → no strobe.
- RAM I/O with src_valid=0 → no strobe.
- Strobes are mutually exclusive; bus_drive=1 only together with a read strobe.
- Reset asserted mid-cycle: all outputs reach reset values at that edge, including any strobe in X2.

Decomposition:
- Package ram_bus_pkg:
  - phase enum (PH_A1..PH_X3).
  - OPR constants (OPR_IO=0xE, OPR_SRC_FIM=0x2, etc.).
  - OPA constants (OPA_WRM, OPA_WMP, OPA_WR0, OPA_SBM, OPA_RDM, OPA_ADM, OPA_RD0).
  - function is_two_cycle(opr, opa).
- Sub-module cycle_phase_counter: sync-driven 3-bit counter with locked and resync outputs.

Test Plan:
- Reset, then sync every 8 clocks → locked=1 on the cycle after the first sync; phase sequence 0..7 repeating; all strobes 0.
- SRC with cm_ram=0b0010, X2 data=0x9, X3 data=0x5 → sel_bank=1, sel_chip=2, sel_reg=1, sel_char=5, src_valid=1 after X3.
- Following WRM (M1=0xE, M2=0x0, cm_ram set), X2 data=0xA → mem_we high for exactly the X2 cycle with wr_data=0xA; no other strobe.
- RD2 (M2=0xE) → status_re=1, status_idx=2, bus_drive=1 in X2 only. Same sequence before any SRC → no strobe.
- JUN (OPR 4) followed by a cycle whose M1/M2 = 0xE/0x0 with cm_ram set → no mem_we in that second cycle.
- sync asserted at phase 3 during an RDM cycle → phase=A1 on the next clock and no mem_re. Reset asserted in X2 of a WRM → mem_we=0 at that edge.
